// File: rtl/rx_det_seq_ctrl_pkg.sv
// Shared definitions for the receiver-detect sequencer: FSM encoding, default
// timing constants and a lane-index helper reused by core_fsm and benches.
package rx_det_seq_ctrl_pkg;

  localparam int DEF_NUM_LANES   = 4;
  localparam int DEF_SETTLE_CYC  = 4;
  localparam int DEF_TIMEOUT_CYC = 64;
  localparam int DEF_CNT_W       = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_PROBE  = 2'd2,
    ST_ACK    = 2'd3
  } det_state_e;

  // Next lane in round-robin order, wrapping for any lane count.
  function automatic int next_lane(input int lane, input int num_lanes);
    return (lane == num_lanes - 1) ? 0 : lane + 1;
  endfunction

endpackage

// File: rtl/rx_det_seq_ctrl_rr_pick.sv
// Combinational round-robin first-one finder: returns the first pending lane
// at or above rr_ptr, wrapping past the top lane back to lane 0.
module rx_det_seq_ctrl_rr_pick
  import rx_det_seq_ctrl_pkg::*;
#(
  parameter  int NUM_LANES = DEF_NUM_LANES,
  localparam int IDX_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic [NUM_LANES-1:0] pend,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic                 gnt_vld
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = IDX_W'((int'(rr_ptr) + k) % NUM_LANES);
      if (!gnt_vld && pend[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/rx_det_seq_ctrl.sv
// Receiver-detect sequencer: serialises per-lane detect requests onto one
// shared analog detect engine with settle/probe timing and timeout handling.
module rx_det_seq_ctrl
  import rx_det_seq_ctrl_pkg::*;
#(
  parameter  int NUM_LANES   = DEF_NUM_LANES,
  parameter  int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter  int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter  int CNT_W       = DEF_CNT_W,
  localparam int IDX_W       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] seq_req,
  output logic [NUM_LANES-1:0] seq_ack,
  output logic [NUM_LANES-1:0] rx_det,
  output logic                 det_start,
  output logic [IDX_W-1:0]     det_lane,
  input  logic                 det_done,
  input  logic                 det_result,
  output logic [NUM_LANES-1:0] det_timeout,
  output logic                 busy
);

  det_state_e state_q, state_d;

  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     rr_ptr;
  logic [NUM_LANES-1:0] served;
  logic [NUM_LANES-1:0] pend;
  logic [NUM_LANES-1:0] lane_oh;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_vld;
  logic                 load_lane, cnt_clr, start_probe;
  logic                 finish_done, finish_to, ack_en;

  assign pend    = seq_req & ~seq_ack & ~served;
  assign lane_oh = NUM_LANES'(1) << det_lane;
  assign busy    = (state_q != ST_IDLE);

  rx_det_seq_ctrl_rr_pick #(.NUM_LANES(NUM_LANES)) u_rr_pick (
    .pend    (pend),
    .rr_ptr  (rr_ptr),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    load_lane   = 1'b0;
    cnt_clr     = 1'b0;
    start_probe = 1'b0;
    finish_done = 1'b0;
    finish_to   = 1'b0;
    ack_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          load_lane = 1'b1;
          cnt_clr   = 1'b1;
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
          cnt_clr     = 1'b1;
          start_probe = 1'b1;
          state_d     = ST_PROBE;
        end
      end
      ST_PROBE: begin
        // A completion landing on the last timeout cycle still counts as done.
        if (det_done) begin
          finish_done = 1'b1;
          state_d     = ST_ACK;
        end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          finish_to = 1'b1;
          state_d   = ST_ACK;
        end
      end
      ST_ACK: begin
        ack_en  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      rr_ptr      <= '0;
      det_lane    <= '0;
      det_start   <= 1'b0;
      seq_ack     <= '0;
      served      <= '0;
      rx_det      <= '0;
      det_timeout <= '0;
    end else begin
      det_start <= start_probe;

      if (cnt_clr)
        cnt <= '0;
      else if (state_q == ST_SETTLE || state_q == ST_PROBE)
        cnt <= cnt + CNT_W'(1);

      // det_lane only moves on a new selection, so it holds through IDLE.
      if (load_lane)
        det_lane <= gnt_idx;

      if (finish_done) begin
        rx_det[det_lane]      <= det_result;
        det_timeout[det_lane] <= 1'b0;
      end else if (finish_to) begin
        rx_det[det_lane]      <= 1'b0;
        det_timeout[det_lane] <= 1'b1;
      end

      if (ack_en)
        rr_ptr <= IDX_W'(next_lane(int'(det_lane), NUM_LANES));

      // Ack and served drop as soon as the request is seen low; a withdrawn
      // request gets its result recorded but never an ack.
      seq_ack <= (seq_ack & seq_req) | ({NUM_LANES{ack_en}} & lane_oh & seq_req);
      served  <= (served  & seq_req) | ({NUM_LANES{ack_en}} & lane_oh & seq_req);
    end
  end

endmodule

// File: doc/rx_det_seq_ctrl.md
Name: rx_det_seq_ctrl

Overview:
- Receiver-detect sequencer between core_fsm and one shared analog detect engine.
- Accepts per-lane detect requests from core_fsm (4-phase req/ack) and serialises them round-robin onto the engine.
- Applies settle and probe timing, handles engine timeouts, and returns per-lane rx_det results plus acks.
- One instance per link; feeds rx_det_valid / rx_det_seq_ack of core_fsm.

Parameters:
NUM_LANES, 4, number of lanes served (widths below shown for 4).
SETTLE_CYC, 4, clk cycles of idle between lane switch and probe start (min 1).
TIMEOUT_CYC, 64, max clk cycles from det_start to det_done before forced fail.
CNT_W, 7, counter width; must hold max(SETTLE_CYC, TIMEOUT_CYC).

Ports:
clk  in  1  1GHz system clock; single clock domain.
rst  in  1  synchronous, active-high reset.
seq_req  in  4  per-lane detect request from core_fsm; level, held until ack seen.
seq_ack  out  4  per-lane ack; high from result-valid until seq_req[i] falls.
rx_det  out  4  per-lane detect result; bit i valid whenever seq_ack[i]=1, holds until lane re-probed.
det_start  out  1  one-cycle pulse launching a probe on det_lane.
det_lane  out  2  lane index driven to engine; stable from SETTLE entry through det_done.
det_done  in  1  engine completion pulse.
det_result  in  1  engine result, sampled only when det_done=1 (1 = receiver present).
det_timeout  out  4  sticky per-lane flag: last probe of lane i timed out; cleared when lane i next gets det_done.
busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, rr_ptr=0, cnt=0. All outputs 0: seq_ack, rx_det, det_start, det_lane, det_timeout, busy. rst mid-probe abandons the probe; a late det_done from the engine is ignored because state is IDLE.
- Pending set: pend = seq_req & ~seq_ack & ~served. served[i] sets at ack, clears when seq_req[i]=0.
- IDLE: if pend != 0, pick the first set bit searching from rr_ptr upward (wraps 3->0). Load det_lane and go to SETTLE with cnt=0.
- SETTLE: count SETTLE_CYC cycles, then go to PROBE. det_start=1 on the PROBE entry cycle only, and cnt resets.
- PROBE: cnt increments each cycle.
  - If det_done: record det_result into rx_det[lane], clear det_timeout[lane], go to ACK.
  - Else if cnt==TIMEOUT_CYC-1: set rx_det[lane]=0, set det_timeout[lane], go to ACK.
  - det_done in the same cycle as timeout expiry: det_done wins.
- ACK (1 cycle):
  - If seq_req[lane] is still 1: set seq_ack[lane]=1 and served[lane]=1.
  - If seq_req[lane] dropped during the probe: the result is still written to rx_det, but no ack is given.
  - rr_ptr = lane+1 (mod NUM_LANES). Return to IDLE.
- seq_ack[i] falls the cycle after seq_req[i] is seen low, independent of FSM state.
- Latency, best case (SETTLE_CYC=4, engine done 1 cycle after start):
  - req rise at cycle 0; IDLE select at cycle 1.
  - SETTLE cycles 1-4; det_start at cycle 5; det_done at cycle 6.
  - ACK at cycle 7; seq_ack high at cycle 8.
- Only one probe outstanding at a time. det_done outside PROBE is ignored.
- Several simultaneous requests are served strictly round-robin, one probe each. A lane re-requesting must drop and re-raise req.
- det_lane holds its last value in IDLE; there is no glitch to 0.

Decomposition:
- Shared package: FSM state encoding (IDLE, SETTLE, PROBE, ACK) and default constants SETTLE_CYC / TIMEOUT_CYC. These are reusable by core_fsm and the testbench.
- One natural sub-module: rr_pick. It is a combinational round-robin first-one finder (inputs: pend[3:0], rr_ptr[1:0]; outputs: gnt_idx[1:0], gnt_vld).
- Counter, served/ack bookkeeping and FSM stay in the top.

Test Plan:
1. Single lane: seq_req=4'b0001, engine returns det_done+det_result=1 one cycle after det_start.
   -> det_start at cycle 5, det_lane=0, seq_ack=0001 at cycle 8, rx_det=0001, det_timeout=0000.
2. All four lanes requested together, engine results 1,0,1,1.
   -> probes issued in order lane 0,1,2,3, each with SETTLE_CYC gap; final rx_det=1101 and seq_ack=1111.
3. Timeout: lane 2 requested, engine never asserts det_done.
   -> 64 cycles after det_start, rx_det[2]=0, det_timeout=0100, seq_ack[2]=1.
   -> Re-request with a successful probe clears det_timeout[2].
4. Round-robin fairness: after lane 3 is served (rr_ptr=0), lanes 1 and 3 both request.
   -> lane 1 is probed first, then lane 3.
   -> Lane 3 kept held high after its ack is not re-probed until it is dropped and re-raised.
5. Request withdrawn mid-probe: seq_req[1] drops during PROBE, det_done arrives with result=1.
   -> rx_det[1]=1, seq_ack[1] stays 0, FSM returns to IDLE and busy=0.
6. Reset mid-probe: assert rst during PROBE on lane 0, then pulse det_done after rst falls.
   -> All outputs are 0 after reset; the late det_done does not change rx_det or seq_ack.
